fetch_stage: RTL and testbench

- Instruction-fetch stage feeding the decode stage.
- Holds the PA-RISC program-counter queue (PC, nPC) and drives the instruction-memory address.
- Latches fetched words into the IF/ID pipeline register.
- Obeys the load-enable stall from the data hazard detection unit, applies delayed-branch redirects, and squashes nullified delay-slot instructions.

---
 rtl/fetch_stage.sv | 51 +++++
 tb/tb_fetch_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PA-RISC PC queue (pc, npc) driving instruction memory,
// plus the IF/ID register with stall, delayed-branch redirect and nullification.
module fetch_stage #(
    parameter int                 PC_W     = 32,
    parameter int                 INSTR_W  = 32,
    parameter logic [PC_W-1:0]    RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               LE,
    input  logic               TA,
    input  logic [PC_W-1:0]    TA_target,
    input  logic               NULLIFY,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    npc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ifid_valid
);
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    logic [PC_W-1:0] npc_next;

    // Taken branch redirects npc only; pc still takes npc so the delay slot runs first.
    always_comb begin
        npc_next = npc + PC_STEP;
        if (TA)
            npc_next = {TA_target[PC_W-1:2], 2'b00};
    end

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            npc        <= RESET_PC + PC_STEP;
            ifid_instr <= NOP_WORD;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else if (LE) begin
            pc         <= npc;
            npc        <= npc_next;
            ifid_pc    <= pc;
            ifid_instr <= NULLIFY ? NOP_WORD : imem_data;
            ifid_valid <= ~NULLIFY;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan scenarios with literal
// expectations, then randomized traffic against a queue-based PC model.
module tb_fetch_stage;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    logic               clk;
    logic               reset;
    logic               LE;
    logic               TA;
    logic [PC_W-1:0]    TA_target;
    logic               NULLIFY;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    npc;
    logic [INSTR_W-1:0] ifid_instr;
    logic [PC_W-1:0]    ifid_pc;
    logic               ifid_valid;

    fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk(clk), .reset(reset), .LE(LE), .TA(TA), .TA_target(TA_target),
        .NULLIFY(NULLIFY), .imem_addr(imem_addr), .imem_data(imem_data),
        .pc(pc), .npc(npc), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .ifid_valid(ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content is a function of the address; mem_xor scrambles it during random traffic.
    logic [INSTR_W-1:0] mem_xor;
    assign imem_data = imem_addr ^ mem_xor;

    int checks;
    int errors;
    logic chk_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the fetch address stream is a two-entry queue; each advance
    // retires the head into IF/ID and appends either the branch target or tail+4.
    logic [PC_W-1:0]    fq[$];
    logic [INSTR_W-1:0] m_instr;
    logic [PC_W-1:0]    m_ipc;
    logic               m_valid;

    always @(posedge clk) begin
        if (reset) begin
            fq.delete();
            fq.push_back(32'h0);
            fq.push_back(32'h4);
            m_instr = 32'h0;
            m_ipc   = 32'h0;
            m_valid = 1'b0;
        end else if (LE && fq.size() == 2) begin
            logic [PC_W-1:0] head;
            logic [PC_W-1:0] tail;
            head = fq.pop_front();
            tail = fq[0];
            m_ipc   = head;
            m_instr = NULLIFY ? 32'h0 : (head ^ mem_xor);
            m_valid = !NULLIFY;
            fq.push_back(TA ? (TA_target & ~32'h3) : tail + 32'h4);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (fq.size() != 2) begin
                chk("model_queue_size", 32'(fq.size()), 32'd2);
            end else begin
                chk("pc", pc, fq[0]);
                chk("npc", npc, fq[1]);
                chk("imem_addr", imem_addr, fq[0]);
                chk("ifid_instr", ifid_instr, m_instr);
                chk("ifid_pc", ifid_pc, m_ipc);
                chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
            end
        end
    end

    // Called at a negedge: apply inputs, let one rising edge pass, return at next negedge.
    task automatic step(input logic le, input logic ta, input logic nul, input logic [31:0] tgt);
        LE = le; TA = ta; NULLIFY = nul; TA_target = tgt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_npc,
                             input logic [31:0] e_ipc, input logic e_val);
        chk({tag, "_pc"}, pc, e_pc);
        chk({tag, "_npc"}, npc, e_npc);
        chk({tag, "_ifid_pc"}, ifid_pc, e_ipc);
        chk({tag, "_ifid_valid"}, 32'(ifid_valid), 32'(e_val));
    endtask

    initial begin
        checks = 0; errors = 0; chk_en = 1'b0; mem_xor = '0;
        reset = 1'b1; LE = 1'b0; TA = 1'b0; NULLIFY = 1'b0; TA_target = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset values
        chk_state("rst", 32'h0, 32'h4, 32'h0, 1'b0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk_en = 1'b1;

        // Sequential fetch, memory word = address
        step(1, 0, 0, 0); chk_state("adv1", 32'h4, 32'h8, 32'h0, 1'b1);
        step(1, 0, 0, 0); chk_state("adv2", 32'h8, 32'hC, 32'h4, 1'b1);
        chk("adv2_instr", ifid_instr, 32'h4);

        // Stall with TA/NULLIFY asserted: everything holds
        step(0, 1, 1, 32'h100); chk_state("stall1", 32'h8, 32'hC, 32'h4, 1'b1);
        step(0, 1, 1, 32'h100); chk_state("stall2", 32'h8, 32'hC, 32'h4, 1'b1);
        step(1, 0, 0, 0);       chk_state("resume", 32'hC, 32'h10, 32'h8, 1'b1);
        chk("resume_instr", ifid_instr, 32'h8);

        // Taken branch at pc=8 with unaligned target
        do_reset();
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        step(1, 1, 0, 32'h43); chk_state("br", 32'hC, 32'h40, 32'h8, 1'b1);
        step(1, 0, 0, 0);      chk_state("br_slot", 32'h40, 32'h44, 32'hC, 1'b1);
        step(1, 0, 0, 0);      chk_state("br_tgt", 32'h44, 32'h48, 32'h40, 1'b1);

        // TA and NULLIFY together at pc=8
        do_reset();
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        step(1, 1, 1, 32'h80); chk_state("nul", 32'hC, 32'h80, 32'h8, 1'b0);
        chk("nul_instr", ifid_instr, 32'h0);
        step(1, 0, 0, 0); chk_state("nul_slot", 32'h80, 32'h84, 32'hC, 1'b1);
        step(1, 0, 0, 0); chk_state("nul_tgt", 32'h84, 32'h88, 32'h80, 1'b1);

        // Wrap-around at the top of the address space
        step(1, 1, 0, 32'hFFFF_FFF8); chk_state("wrap0", 32'h88, 32'hFFFF_FFF8, 32'h84, 1'b1);
        step(1, 0, 0, 0); chk_state("wrap1", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h88, 1'b1);
        step(1, 0, 0, 0); chk_state("wrap2", 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFF8, 1'b1);
        step(1, 0, 0, 0); chk_state("wrap3", 32'h0, 32'h4, 32'hFFFF_FFFC, 1'b1);

        // Reset overrides LE/TA
        reset = 1'b1;
        step(1, 1, 0, 32'h200);
        reset = 1'b0;
        chk_state("rst_ovr", 32'h0, 32'h4, 32'h0, 1'b0);
        chk("rst_ovr_instr", ifid_instr, 32'h0);

        // Randomized traffic against the model
        mem_xor = $urandom;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0, $urandom);
            if (i % 500 == 499) mem_xor = $urandom;
        end
        reset = 1'b0;
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
